// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: synchronises RxD, validates the start bit and strobes
// each data bit (LSB first) at mid-bit, then checks the stop bit.
module uart_rx_bit_sampler #(
    parameter int BaudDiv  = 868,
    parameter int DataBits = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic RxD,
    output logic SerDataOut,
    output logic SerDataEn,
    output logic RxBusy,
    output logic RxDone,
    output logic RxFrameErr
);

    localparam int CW = $clog2(BaudDiv);
    localparam int IW = $clog2(DataBits + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BaudDiv - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(BaudDiv / 2 - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(DataBits - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Valid/ready: none. SerDataEn is a one-cycle strobe; the consumer must
    // capture SerDataOut in that cycle and cannot stall the sampler.

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] bitidx_q, bitidx_d;
    logic          sync1_q, rxs_q, rxs_dly_q;
    logic          ser_data_q, ser_data_d;
    logic          ser_en_q, ser_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitidx_d   = bitidx_q;
        ser_data_d = ser_data_q;
        ser_en_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a genuine high-to-low transition arms; a stuck-low line never does.
                if (rxs_dly_q && !rxs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d  = DATA;
                        bitidx_d = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    ser_data_d = rxs_q;
                    ser_en_d   = 1'b1;
                    bitidx_d   = bitidx_q + IW'(1);
                    if (bitidx_q == BIT_LAST) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = rxs_q;
                    ferr_d  = !rxs_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitidx_q   <= '0;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_dly_q  <= 1'b1;
            ser_data_q <= 1'b0;
            ser_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitidx_q   <= bitidx_d;
            sync1_q    <= RxD;
            rxs_q      <= sync1_q;
            rxs_dly_q  <= rxs_q;
            ser_data_q <= ser_data_d;
            ser_en_q   <= ser_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign SerDataOut = ser_data_q;
    assign SerDataEn  = ser_en_q;
    assign RxBusy     = busy_q;
    assign RxDone     = done_q;
    assign RxFrameErr = ferr_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler at BaudDiv=16, DataBits=8 (clock period 10 units).
module tb_uart_rx_bit_sampler;

    localparam int BAUD = 16;
    localparam int BIT_T = 160;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic RxD = 1'b1;
    logic SerDataOut, SerDataEn, RxBusy, RxDone, RxFrameErr;

    uart_rx_bit_sampler #(.BaudDiv(BAUD), .DataBits(8)) dut (
        .Clk(Clk), .Rst(Rst), .RxD(RxD),
        .SerDataOut(SerDataOut), .SerDataEn(SerDataEn),
        .RxBusy(RxBusy), .RxDone(RxDone), .RxFrameErr(RxFrameErr)
    );

    always #5 Clk = ~Clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [0:0] exp_q[$];
    logic [7:0] got_q[$];

    int cyc = 0, strobe_cnt = 0, done_cnt = 0, ferr_cnt = 0, both_cnt = 0;
    int busy_rises = 0, busy_len = 0, busy_rise_cyc = 0, last_strobe_cyc = 0;
    int frame_strobes = 0;
    logic [7:0] shreg = '0;
    logic busy_prev = 1'b0;
    int s0, d0, f0, b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Scoreboard/monitor: samples 1 unit after each rising edge and models the
    // downstream MSB-shift ser2par register.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            if (Rst) begin
                frame_strobes = 0;
                busy_prev = 1'b0;
            end else begin
                if (RxBusy && !busy_prev) begin
                    busy_rise_cyc = cyc;
                    busy_rises++;
                end
                if (!RxBusy && busy_prev) busy_len = cyc - busy_rise_cyc;
                busy_prev = RxBusy;
                if (SerDataEn) begin
                    if (frame_strobes == 0) check("first_strobe_lat", cyc - busy_rise_cyc, BAUD/2 + BAUD);
                    else check("strobe_spacing", cyc - last_strobe_cyc, BAUD);
                    if (exp_q.size() == 0) check("strobe_unexpected", 32'(SerDataEn), 0);
                    else check("ser_bit", 32'(SerDataOut), 32'(exp_q.pop_front()));
                    shreg = {SerDataOut, shreg[7:1]};
                    strobe_cnt++;
                    frame_strobes++;
                    last_strobe_cyc = cyc;
                end
                if (RxDone && RxFrameErr) both_cnt++;
                if (RxDone || RxFrameErr) begin
                    check("frame_bits", frame_strobes, 8);
                    got_q.push_back(shreg);
                    frame_strobes = 0;
                end
                if (RxDone) done_cnt++;
                if (RxFrameErr) ferr_cnt++;
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bit_t);
        for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
        RxD = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            RxD = data[i];
            #(bit_t);
        end
        RxD = stop_bit;
        #(bit_t);
    endtask

    task automatic snap();
        s0 = strobe_cnt;
        d0 = done_cnt;
        f0 = ferr_cnt;
        b0 = busy_rises;
    endtask

    task automatic check_last_byte(input string tag, input logic [7:0] want, input int back);
        if (got_q.size() < back) check(tag, got_q.size(), back);
        else check(tag, 32'(got_q[got_q.size() - back]), 32'(want));
    endtask

    initial begin
        logic [7:0] part;
        // Reset values
        repeat (3) @(negedge Clk);
        check("rst_serdataout", 32'(SerDataOut), 0);
        check("rst_serdataen", 32'(SerDataEn), 0);
        check("rst_busy", 32'(RxBusy), 0);
        check("rst_done", 32'(RxDone), 0);
        check("rst_ferr", 32'(RxFrameErr), 0);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);
        check("idle_busy", 32'(RxBusy), 0);

        // Nominal frame 0xA5
        snap();
        send_frame(8'hA5, 1'b1, BIT_T);
        repeat (8) @(negedge Clk);
        check("a5_strobes", strobe_cnt - s0, 8);
        check("a5_done", done_cnt - d0, 1);
        check("a5_ferr", ferr_cnt - f0, 0);
        check_last_byte("a5_byte", 8'hA5, 1);
        check("a5_busy_end", 32'(RxBusy), 0);

        // Reset during DATA after three strobes
        snap();
        part = 8'h96;
        for (int i = 0; i < 3; i++) exp_q.push_back(part[i]);
        RxD = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 3; i++) begin
            RxD = part[i];
            #(BIT_T);
        end
        RxD = part[3];
        #40;
        check("rstmid_strobes_before", strobe_cnt - s0, 3);
        Rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(RxBusy), 0);
        check("rstmid_serdataen", 32'(SerDataEn), 0);
        check("rstmid_serdataout", 32'(SerDataOut), 0);
        check("rstmid_done", 32'(RxDone), 0);
        check("rstmid_ferr", 32'(RxFrameErr), 0);
        RxD = 1'b1;
        repeat (4) @(negedge Clk);
        Rst = 1'b0;
        repeat (30) @(negedge Clk);
        check("rstmid_strobes_after", strobe_cnt - s0, 3);
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_queue_empty", exp_q.size(), 0);
        snap();
        send_frame(8'hC3, 1'b1, BIT_T);
        repeat (8) @(negedge Clk);
        check("postrst_done", done_cnt - d0, 1);
        check_last_byte("postrst_byte", 8'hC3, 1);

        // Start-bit glitch: 5 cycles low
        snap();
        RxD = 1'b0;
        repeat (5) @(negedge Clk);
        RxD = 1'b1;
        repeat (30) @(negedge Clk);
        check("glitch_strobes", strobe_cnt - s0, 0);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_rises", busy_rises - b0, 1);
        check("glitch_busy_len", busy_len, BAUD/2);

        // Framing error 0x3C, line then held low
        snap();
        send_frame(8'h3C, 1'b0, BIT_T);
        repeat (40) @(negedge Clk);
        check("ferr_strobes", strobe_cnt - s0, 8);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_no_done", done_cnt - d0, 0);
        check_last_byte("ferr_byte", 8'h3C, 1);
        check("ferr_no_rearm", busy_rises - b0, 1);
        check("ferr_busy_low", 32'(RxBusy), 0);
        RxD = 1'b1;
        repeat (20) @(negedge Clk);

        // Back-to-back 0x00 then 0xFF, zero idle gap
        snap();
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        repeat (8) @(negedge Clk);
        check("b2b_strobes", strobe_cnt - s0, 16);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_ferr", ferr_cnt - f0, 0);
        check_last_byte("b2b_byte0", 8'h00, 2);
        check_last_byte("b2b_byte1", 8'hFF, 1);

        // Baud tolerance: about -3% and +3% bit period
        snap();
        send_frame(8'h6B, 1'b1, 155);
        repeat (3) @(negedge Clk);
        send_frame(8'hD2, 1'b1, 165);
        repeat (8) @(negedge Clk);
        check("baud_done", done_cnt - d0, 2);
        check("baud_ferr", ferr_cnt - f0, 0);
        check_last_byte("baud_fast_byte", 8'h6B, 2);
        check_last_byte("baud_slow_byte", 8'hD2, 1);

        check("never_done_and_ferr", both_cnt, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
